load_store_unit: RTL and testbench

Memory-access stage that sits directly upstream of the data memory. It accepts one load or store request at a time from the execute stage over a valid/ready handshake. It sequences the memory's `mem_read` and `mem_write` enables, addresses and write data, and rejects out-of-range addresses. It returns every completed operation to writeback over a second valid/ready handshake, with load data for loads.

---
 rtl/load_store_unit.sv | 142 ++++++++++++++
 tb/tb_load_store_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-access stage: serializes one load/store at a time toward the data memory,
// range-checks addresses and returns each completed operation to writeback.
module load_store_unit #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int MEM_DEPTH = 70,
    parameter int READ_LAT  = 1,
    parameter int REG_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [ADDR_W-1:0] req_addr2,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [REG_W-1:0]  req_rd,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] read_address1,
    output logic [ADDR_W-1:0] read_address2,
    output logic [ADDR_W-1:0] write_address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] mem_rdata1,
    input  logic [DATA_W-1:0] mem_rdata2,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [1:0]        resp_op,
    output logic [REG_W-1:0]  resp_rd,
    output logic [DATA_W-1:0] resp_data1,
    output logic [DATA_W-1:0] resp_data2,
    output logic              resp_err
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_PAIR  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_DEPTH);
    localparam logic [2:0] WAIT_INIT = 3'((READ_LAT > 1) ? READ_LAT - 2 : 0);

    state_t            state_reg, state_next;
    logic [2:0]        cnt_reg, cnt_next;
    logic [1:0]        op_reg;
    logic [REG_W-1:0]  rd_reg;
    logic [ADDR_W-1:0] addr1_reg, addr2_reg;
    logic [DATA_W-1:0] wdata_reg, data1_reg, data2_reg;
    logic              err_reg;

    logic accept;
    logic req_err;

    assign accept  = req_valid && (state_reg == IDLE);
    assign req_err = (req_addr1 >= ADDR_LIMIT) ||
                     ((req_op == OP_PAIR) && (req_addr2 >= ADDR_LIMIT));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept && (req_op != OP_NOP)) begin
                    if (req_err)
                        state_next = RESP;
                    else if (req_op == OP_STORE)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ: begin
                if (READ_LAT > 1) begin
                    state_next = WAIT;
                    cnt_next   = WAIT_INIT;
                end else begin
                    state_next = RESP;
                end
            end
            WAIT: begin
                if (cnt_reg == 3'd0)
                    state_next = RESP;
                else
                    cnt_next = cnt_reg - 3'd1;
            end
            WRITE: state_next = RESP;
            RESP: begin
                if (resp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
            op_reg    <= 2'b00;
            rd_reg    <= '0;
            addr1_reg <= '0;
            addr2_reg <= '0;
            wdata_reg <= '0;
            data1_reg <= '0;
            data2_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            // nops are dropped without touching the latched request, so the
            // memory-port outputs keep their last values while idle
            if (accept && (req_op != OP_NOP)) begin
                op_reg    <= req_op;
                rd_reg    <= req_rd;
                addr1_reg <= req_addr1;
                addr2_reg <= req_addr2;
                wdata_reg <= req_wdata;
                err_reg   <= req_err;
                data1_reg <= '0;
                data2_reg <= '0;
            end
            if (((state_reg == READ) || (state_reg == WAIT)) && (state_next == RESP)) begin
                data1_reg <= mem_rdata1;
                data2_reg <= (op_reg == OP_PAIR) ? mem_rdata2 : '0;
            end
        end
    end

    assign req_ready     = (state_reg == IDLE);
    assign mem_read      = (state_reg == READ);
    assign mem_write     = (state_reg == WRITE);
    assign resp_valid    = (state_reg == RESP);
    assign read_address1 = addr1_reg;
    assign read_address2 = addr2_reg;
    assign write_address = addr1_reg;
    assign write_data    = wdata_reg;
    assign resp_op       = op_reg;
    assign resp_rd       = rd_reg;
    assign resp_data1    = data1_reg;
    assign resp_data2    = data2_reg;
    assign resp_err      = err_reg;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a READ_LAT=1 unit with a behavioural memory,
// plus a READ_LAT=3 unit for wait-state latency and mid-operation reset.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset, reset3;
    logic        req_valid, req_valid3;
    logic [1:0]  req_op;
    logic [15:0] req_addr1, req_addr2, req_wdata;
    logic [2:0]  req_rd;
    logic        resp_ready, resp_ready3;

    logic        req_ready, mem_read, mem_write, resp_valid, resp_err;
    logic [15:0] read_address1, read_address2, write_address, write_data;
    logic [15:0] mem_rdata1, mem_rdata2, resp_data1, resp_data2;
    logic [1:0]  resp_op;
    logic [2:0]  resp_rd;

    logic        req_ready3, mem_read3, mem_write3, resp_valid3, resp_err3;
    logic [15:0] read_address1_3, read_address2_3, write_address3, write_data3;
    logic [15:0] mem_rdata1_3, mem_rdata2_3, resp_data1_3, resp_data2_3;
    logic [1:0]  resp_op3;
    logic [2:0]  resp_rd3;

    logic [15:0] mem [0:127];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk)
        if (mem_write) mem[write_address[6:0]] <= write_data;

    assign mem_rdata1   = mem[read_address1[6:0]];
    assign mem_rdata2   = mem[read_address2[6:0]];
    assign mem_rdata1_3 = mem[read_address1_3[6:0]];
    assign mem_rdata2_3 = mem[read_address2_3[6:0]];

    load_store_unit #(.READ_LAT(1)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr1(req_addr1), .req_addr2(req_addr2),
        .req_wdata(req_wdata), .req_rd(req_rd), .mem_read(mem_read),
        .mem_write(mem_write), .read_address1(read_address1),
        .read_address2(read_address2), .write_address(write_address),
        .write_data(write_data), .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_op(resp_op),
        .resp_rd(resp_rd), .resp_data1(resp_data1), .resp_data2(resp_data2),
        .resp_err(resp_err)
    );

    load_store_unit #(.READ_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_op(req_op), .req_addr1(req_addr1), .req_addr2(req_addr2),
        .req_wdata(req_wdata), .req_rd(req_rd), .mem_read(mem_read3),
        .mem_write(mem_write3), .read_address1(read_address1_3),
        .read_address2(read_address2_3), .write_address(write_address3),
        .write_data(write_data3), .mem_rdata1(mem_rdata1_3), .mem_rdata2(mem_rdata2_3),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_op(resp_op3),
        .resp_rd(resp_rd3), .resp_data1(resp_data1_3), .resp_data2(resp_data2_3),
        .resp_err(resp_err3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request on the READ_LAT=1 unit with resp_ready high and check the whole exchange.
    task automatic run_op(input string name, input logic [1:0] op, input logic [15:0] a1,
                          input logic [15:0] a2, input logic [15:0] wd, input logic [2:0] rd,
                          input int exp_lat, input logic exp_err,
                          input logic [15:0] e1, input logic [15:0] e2);
        int cyc, nr, nw, both;
        int exp_nr, exp_nw;
        exp_nr = (!exp_err && (op == 2'b01 || op == 2'b10)) ? 1 : 0;
        exp_nw = (!exp_err && op == 2'b11) ? 1 : 0;
        check({name, ".req_ready"}, 32'(req_ready), 1);
        req_valid = 1'b1; req_op = op; req_addr1 = a1; req_addr2 = a2;
        req_wdata = wd; req_rd = rd; resp_ready = 1'b1;
        tick();
        req_valid = 1'b0; req_op = 2'b11; req_addr1 = 16'h0003; req_wdata = 16'h5555; req_rd = 3'd7;
        cyc = 1; nr = 32'(mem_read); nw = 32'(mem_write); both = 32'(mem_read & mem_write);
        while (!resp_valid && cyc < 16) begin
            tick();
            cyc++;
            nr += 32'(mem_read); nw += 32'(mem_write); both += 32'(mem_read & mem_write);
        end
        check({name, ".latency"}, 32'(cyc), 32'(exp_lat));
        check({name, ".mem_read_pulses"}, 32'(nr), 32'(exp_nr));
        check({name, ".mem_write_pulses"}, 32'(nw), 32'(exp_nw));
        check({name, ".rd_wr_overlap"}, 32'(both), 0);
        check({name, ".resp_err"}, 32'(resp_err), 32'(exp_err));
        check({name, ".resp_data1"}, 32'(resp_data1), 32'(e1));
        check({name, ".resp_data2"}, 32'(resp_data2), 32'(e2));
        check({name, ".resp_rd"}, 32'(resp_rd), 32'(rd));
        check({name, ".resp_op"}, 32'(resp_op), 32'(op));
        check({name, ".read_address1"}, 32'(read_address1), 32'(a1));
        check({name, ".write_data"}, 32'(write_data), 32'(wd));
        $display("op %s: op=%0d a1=%0h a2=%0h rd=%0d lat=%0d err=%0b d1=%0h d2=%0h",
                 name, op, a1, a2, rd, cyc, resp_err, resp_data1, resp_data2);
        tick();
        check({name, ".resp_valid_after"}, 32'(resp_valid), 0);
        check({name, ".req_ready_after"}, 32'(req_ready), 1);
    endtask

    initial begin
        int cyc;
        reset = 1'b1; reset3 = 1'b1;
        req_valid = 1'b0; req_valid3 = 1'b0; req_op = 2'b00;
        req_addr1 = 16'h0; req_addr2 = 16'h0; req_wdata = 16'h0; req_rd = 3'd0;
        resp_ready = 1'b1; resp_ready3 = 1'b1;
        tick(); tick();
        check("rst.req_ready", 32'(req_ready), 1);
        check("rst.mem_read", 32'(mem_read), 0);
        check("rst.mem_write", 32'(mem_write), 0);
        check("rst.resp_valid", 32'(resp_valid), 0);
        check("rst.resp_err", 32'(resp_err), 0);
        check("rst.addrs", 32'({read_address1, write_address}), 0);
        check("rst.data", 32'({resp_data1, write_data}), 0);
        check("rst.tag_op", 32'({resp_rd, resp_op}), 0);
        $display("reset applied");
        reset = 1'b0; reset3 = 1'b0;

        run_op("store5", 2'b11, 16'd5, 16'd0, 16'hBEEF, 3'd2, 2, 1'b0, 16'h0, 16'h0);
        run_op("load5", 2'b01, 16'd5, 16'd70, 16'h0, 3'd4, 2, 1'b0, 16'hBEEF, 16'h0);
        run_op("store10", 2'b11, 16'd10, 16'd0, 16'h1234, 3'd1, 2, 1'b0, 16'h0, 16'h0);
        run_op("store69", 2'b11, 16'd69, 16'd0, 16'hABCD, 3'd3, 2, 1'b0, 16'h0, 16'h0);
        run_op("pair", 2'b10, 16'd10, 16'd69, 16'h0, 3'd6, 2, 1'b0, 16'h1234, 16'hABCD);
        run_op("pair_err", 2'b10, 16'd10, 16'd70, 16'h0, 3'd1, 1, 1'b1, 16'h0, 16'h0);
        run_op("store_err", 2'b11, 16'hFFFF, 16'd0, 16'h7777, 3'd5, 1, 1'b1, 16'h0, 16'h0);
        run_op("load70_err", 2'b01, 16'd70, 16'd0, 16'h0, 3'd0, 1, 1'b1, 16'h0, 16'h0);

        // Backpressure: hold the load-pair response for 5 cycles while offering a store.
        req_valid = 1'b1; req_op = 2'b10; req_addr1 = 16'd10; req_addr2 = 16'd69; req_rd = 3'd5;
        resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        cyc = 1;
        while (!resp_valid && cyc < 16) begin tick(); cyc++; end
        check("bp.latency", 32'(cyc), 2);
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_op = 2'b11; req_addr1 = 16'd7; req_wdata = 16'hDEAD; req_rd = 3'd1;
            tick();
            check("bp.resp_valid", 32'(resp_valid), 1);
            check("bp.req_ready", 32'(req_ready), 0);
            check("bp.mem_write", 32'(mem_write), 0);
            check("bp.data", 32'({resp_data1, resp_data2}), 32'h1234ABCD);
            check("bp.tag", 32'({resp_rd, resp_op}), 32'({3'd5, 2'b10}));
        end
        $display("backpressure held 5 cycles: d1=%0h d2=%0h rd=%0d", resp_data1, resp_data2, resp_rd);
        req_valid = 1'b0; resp_ready = 1'b1;
        tick();
        check("bp.release_valid", 32'(resp_valid), 0);
        check("bp.release_ready", 32'(req_ready), 1);

        // Nop: accepted, no response.
        req_valid = 1'b1; req_op = 2'b00; req_addr1 = 16'd33;
        tick();
        req_valid = 1'b0;
        check("nop.req_ready", 32'(req_ready), 1);
        check("nop.resp_valid", 32'(resp_valid), 0);
        tick();
        check("nop.resp_valid2", 32'(resp_valid), 0);
        check("nop.mem_enables", 32'({mem_read, mem_write}), 0);
        $display("nop dropped");

        run_op("b2b_st20", 2'b11, 16'd20, 16'd0, 16'h1111, 3'd1, 2, 1'b0, 16'h0, 16'h0);
        run_op("b2b_ld20", 2'b01, 16'd20, 16'd0, 16'h0, 3'd2, 2, 1'b0, 16'h1111, 16'h0);
        run_op("b2b_st21", 2'b11, 16'd21, 16'd0, 16'h2222, 3'd3, 2, 1'b0, 16'h0, 16'h0);
        run_op("b2b_ld21", 2'b01, 16'd21, 16'd0, 16'h0, 3'd4, 2, 1'b0, 16'h2222, 16'h0);

        // READ_LAT=3 unit: full load latency, then reset in the first WAIT cycle.
        req_valid3 = 1'b1; req_op = 2'b01; req_addr1 = 16'd69; req_rd = 3'd6;
        tick();
        req_valid3 = 1'b0;
        cyc = 1;
        while (!resp_valid3 && cyc < 16) begin tick(); cyc++; end
        check("lat3.latency", 32'(cyc), 4);
        check("lat3.data1", 32'(resp_data1_3), 32'hABCD);
        check("lat3.rd", 32'(resp_rd3), 6);
        $display("lat3 load: lat=%0d d1=%0h", cyc, resp_data1_3);
        tick();
        check("lat3.req_ready", 32'(req_ready3), 1);

        req_valid3 = 1'b1; req_op = 2'b01; req_addr1 = 16'd10; req_rd = 3'd2;
        tick();
        req_valid3 = 1'b0;
        check("rstwait.read_pulse", 32'(mem_read3), 1);
        tick();
        check("rstwait.in_wait", 32'({mem_read3, resp_valid3, req_ready3}), 0);
        reset3 = 1'b1;
        tick();
        reset3 = 1'b0;
        check("rstwait.req_ready", 32'(req_ready3), 1);
        check("rstwait.mem_read", 32'(mem_read3), 0);
        check("rstwait.resp_valid", 32'(resp_valid3), 0);
        check("rstwait.addr", 32'(read_address1_3), 0);
        tick(); tick();
        check("rstwait.no_resp", 32'(resp_valid3), 0);
        $display("reset during WAIT aborted load");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
